ss_host_master: RTL and testbench

Host-end master for the synchronous-serial link served by `comm_fpga_ss`; it plays the role normally taken by the USB microcontroller. It generates `serClk`, shifts host bytes out to the FPGA-side responder and clocks response bytes back. It sits in the FPGA-to-FPGA bridge and loopback-test designs, fed by byte streams from a local command sequencer.

---
 rtl/ss_pkg.sv | 16 +
 rtl/ss_clkgen.sv | 50 +++++
 rtl/ss_host_master.sv | 149 ++++++++++++++
 tb/tb_ss_host_master.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ss_pkg.sv
// Shared state encoding and line-framing constants for the synchronous-serial host master.
package ss_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_RDY,
    TX_SHIFT,
    RX_HUNT,
    RX_SHIFT
  } ss_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic IDLE_BIT  = 1'b1;
  localparam int   DATA_BITS = 8;

endpackage

// File: rtl/ss_clkgen.sv
// serClk divider: idles high when disabled, starts with a low phase when enabled,
// and flags the cycle before each falling/rising edge with a one-cycle strobe.
module ss_clkgen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic serClk_o,
  output logic rise_stb_o,
  output logic fall_stb_o
);

  localparam logic [7:0] PHASE_LAST = 8'(CLK_DIV - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       serClk_q, serClk_d;
  logic       phaseEnd;

  assign phaseEnd   = (cnt_q == PHASE_LAST);
  assign fall_stb_o = en_i && serClk_q && phaseEnd;
  assign rise_stb_o = en_i && !serClk_q && phaseEnd;
  assign serClk_o   = serClk_q;

  // Parking the counter at its terminal value makes the first enabled cycle a fall.
  always_comb begin
    cnt_d    = cnt_q;
    serClk_d = serClk_q;
    if (!en_i) begin
      cnt_d    = PHASE_LAST;
      serClk_d = 1'b1;
    end else if (phaseEnd) begin
      cnt_d    = '0;
      serClk_d = ~serClk_q;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= PHASE_LAST;
      serClk_q <= 1'b1;
    end else begin
      cnt_q    <= cnt_d;
      serClk_q <= serClk_d;
    end
  end

endmodule

// File: rtl/ss_host_master.sv
// Host-end master for the synchronous-serial link: frames host bytes onto serData_out
// and hunts for, then shifts in, response bytes from serData_in.
module ss_host_master
  import ss_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int HUNT_MAX = 1024
) (
  input  logic       clk_in,
  input  logic       reset_in,
  output logic       serClk_out,
  output logic       serData_out,
  input  logic       serData_in,
  input  logic [7:0] txData_in,
  input  logic       txValid_in,
  output logic       txReady_out,
  input  logic       rdReq_in,
  output logic       rdAck_out,
  output logic [7:0] rxData_out,
  output logic       rxValid_out,
  input  logic       rxReady_in,
  output logic       timeout_out
);

  localparam int HUNT_W = $clog2(HUNT_MAX + 1);
  localparam logic [HUNT_W-1:0] HUNT_LAST = HUNT_W'(HUNT_MAX - 1);
  localparam logic [3:0] TX_LAST_BIT = 4'(DATA_BITS + 1);
  localparam logic [3:0] RX_LAST_BIT = 4'(DATA_BITS - 1);

  ss_state_e         state_q;
  logic [7:0]        shreg_q, rxShreg_q, rxData_q;
  logic [3:0]        bitCnt_q;
  logic [HUNT_W-1:0] huntCnt_q;
  logic              sdiMeta_q, sdiSync_q, sdi_s;
  logic              serData_q, txReady_q, rdAck_q, rxValid_q, timeout_q;
  logic              clkEn, riseStb, fallStb;

  assign clkEn = (state_q == TX_SHIFT) || (state_q == RX_HUNT) || (state_q == RX_SHIFT);

  ss_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .clk_i      (clk_in),
    .rst_ni     (reset_in),
    .en_i       (clkEn),
    .serClk_o   (serClk_out),
    .rise_stb_o (riseStb),
    .fall_stb_o (fallStb)
  );

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      sdiMeta_q <= 1'b1;
      sdiSync_q <= 1'b1;
    end else begin
      sdiMeta_q <= serData_in;
      sdiSync_q <= sdiMeta_q;
    end
  end

  assign sdi_s = sdiSync_q;

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      rxShreg_q <= '0;
      bitCnt_q  <= '0;
      huntCnt_q <= '0;
      serData_q <= IDLE_BIT;
      txReady_q <= 1'b0;
      rdAck_q   <= 1'b0;
      rxData_q  <= '0;
      rxValid_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      rdAck_q   <= 1'b0;
      timeout_q <= 1'b0;
      if (rxValid_q && rxReady_in) rxValid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          txReady_q <= 1'b1;
          bitCnt_q  <= '0;
          huntCnt_q <= '0;
          if (txReady_q && txValid_in) begin
            shreg_q   <= txData_in;
            txReady_q <= 1'b0;
            state_q   <= WAIT_RDY;
          end else if (txReady_q && rdReq_in && !rxValid_q) begin
            rdAck_q   <= 1'b1;
            txReady_q <= 1'b0;
            state_q   <= RX_HUNT;
          end
        end
        WAIT_RDY: if (sdi_s) state_q <= TX_SHIFT;
        // bitCnt counts completed rising edges: 0 -> start bit due, 9 -> frame done.
        TX_SHIFT: begin
          if (riseStb && bitCnt_q != TX_LAST_BIT) bitCnt_q <= bitCnt_q + 4'd1;
          if (fallStb) begin
            if (bitCnt_q == TX_LAST_BIT) begin
              serData_q <= IDLE_BIT;
              txReady_q <= 1'b1;
              state_q   <= IDLE;
            end else if (bitCnt_q == 4'd0) begin
              serData_q <= START_BIT;
            end else begin
              serData_q <= shreg_q[0];
              shreg_q   <= shreg_q >> 1;
            end
          end
        end
        RX_HUNT: begin
          if (riseStb) begin
            if (sdi_s == START_BIT) begin
              bitCnt_q <= '0;
              state_q  <= RX_SHIFT;
            end else if (huntCnt_q == HUNT_LAST) begin
              timeout_q <= 1'b1;
              txReady_q <= 1'b1;
              state_q   <= IDLE;
            end else begin
              huntCnt_q <= huntCnt_q + 1'b1;
            end
          end
        end
        RX_SHIFT: begin
          if (riseStb) begin
            rxShreg_q <= {sdi_s, rxShreg_q[7:1]};
            if (bitCnt_q == RX_LAST_BIT) begin
              rxData_q  <= {sdi_s, rxShreg_q[7:1]};
              rxValid_q <= 1'b1;
              txReady_q <= 1'b1;
              state_q   <= IDLE;
            end else begin
              bitCnt_q <= bitCnt_q + 4'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign serData_out = serData_q;
  assign txReady_out = txReady_q;
  assign rdAck_out   = rdAck_q;
  assign rxData_out  = rxData_q;
  assign rxValid_out = rxValid_q;
  assign timeout_out = timeout_q;

endmodule

// File: tb/tb_ss_host_master.sv
// Randomized bench for ss_host_master with an in-bench responder and a
// transaction-level model of frames, hunts and timeouts.
module tb_ss_host_master;

  localparam int CLK_DIV  = 4;
  localparam int HUNT_MAX = 16;
  localparam int FRAME_CYCLES = 2 * CLK_DIV * 9;

  logic       clk_in = 1'b0;
  logic       reset_in = 1'b0;
  logic       serData_in = 1'b1;
  logic [7:0] txData_in = 8'h00;
  logic       txValid_in = 1'b0;
  logic       rdReq_in = 1'b0;
  logic       rxReady_in = 1'b0;
  logic       serClk_out, serData_out, txReady_out, rdAck_out, rxValid_out, timeout_out;
  logic [7:0] rxData_out;

  int testsRun = 0;
  int testsFailed = 0;
  int lineViol = 0;
  logic prevSdo = 1'b1;

  ss_host_master #(.CLK_DIV(CLK_DIV), .HUNT_MAX(HUNT_MAX)) dut (
    .clk_in      (clk_in),
    .reset_in    (reset_in),
    .serClk_out  (serClk_out),
    .serData_out (serData_out),
    .serData_in  (serData_in),
    .txData_in   (txData_in),
    .txValid_in  (txValid_in),
    .txReady_out (txReady_out),
    .rdReq_in    (rdReq_in),
    .rdAck_out   (rdAck_out),
    .rxData_out  (rxData_out),
    .rxValid_out (rxValid_out),
    .rxReady_in  (rxReady_in),
    .timeout_out (timeout_out)
  );

  always #5 clk_in = ~clk_in;

  // serData_out may only move while serClk_out is low.
  always @(negedge clk_in) begin
    if (reset_in && (serData_out !== prevSdo) && serClk_out) lineViol <= lineViol + 1;
    prevSdo <= serData_out;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(negedge clk_in);
  endtask

  // Responder line value driven after falling edge f for a byte preceded by 'idle' idle bits.
  function automatic logic respBit(input int f, input int idle, input logic [7:0] b);
    if (f <= idle) return 1'b1;
    if (f == idle + 1) return 1'b0;
    if (f <= idle + 9) return b[f - idle - 2];
    return 1'b1;
  endfunction

  task automatic doTx(input logic [7:0] b, input int hold, output int ackSeen);
    logic [8:0] expBits, gotBits;
    int nBits, cycles, n;
    logic prevClk, stayHigh;
    expBits = {b, 1'b0};
    gotBits = '0;
    ackSeen = 0;
    if (hold > 0) begin
      serData_in = 1'b0;
      repeat (3) tick();
    end
    txData_in  = b;
    txValid_in = 1'b1;
    cycles = 0;
    while (!txReady_out && cycles < 2000) begin
      tick();
      cycles++;
    end
    tick();
    txValid_in = 1'b0;
    checkOutput("txReadyDrop", txReady_out, 0);
    if (hold > 0) begin
      stayHigh = 1'b1;
      for (int i = 0; i < hold; i++) begin
        if (serClk_out !== 1'b1) stayHigh = 1'b0;
        tick();
      end
      checkOutput("bpClkHigh", stayHigh, 1);
      serData_in = 1'b1;
    end
    n = 0;
    while (serClk_out !== 1'b0 && n < 20) begin
      tick();
      n++;
    end
    checkOutput(hold > 0 ? "bpLatency" : "txLatency", n, hold > 0 ? 4 : 2);
    prevClk = 1'b0;
    nBits = 0;
    cycles = 0;
    while (!txReady_out && cycles < FRAME_CYCLES + 20) begin
      tick();
      cycles++;
      if (rdAck_out) ackSeen++;
      if (!prevClk && serClk_out && nBits < 9) begin
        gotBits[nBits] = serData_out;
        nBits++;
      end
      prevClk = serClk_out;
    end
    checkOutput("txBitCount", nBits, 9);
    checkOutput("txBits", gotBits, expBits);
    checkOutput("txFrameLen", cycles, FRAME_CYCLES);
    checkOutput("txIdleData", serData_out, 1);
  endtask

  task automatic doRead(input logic [7:0] b, input int idle);
    int cycles, falls, rises, extraAck, sdoLow;
    logic prevClk, sawTimeout;
    rdReq_in = 1'b1;
    cycles = 0;
    while (!rdAck_out && cycles < 2000) begin
      tick();
      cycles++;
    end
    rdReq_in = 1'b0;
    checkOutput("rdAck", rdAck_out, 1);
    if (!rdAck_out) return;
    prevClk = serClk_out;
    falls = 0;
    rises = 0;
    extraAck = 0;
    sdoLow = 0;
    sawTimeout = 1'b0;
    cycles = 0;
    while (cycles < 2 * CLK_DIV * (HUNT_MAX + 12)) begin
      tick();
      cycles++;
      if (rdAck_out) extraAck++;
      if (!serData_out) sdoLow++;
      if (prevClk && !serClk_out) begin
        falls++;
        serData_in = respBit(falls, idle, b);
      end
      if (!prevClk && serClk_out) rises++;
      prevClk = serClk_out;
      if (timeout_out) begin
        sawTimeout = 1'b1;
        break;
      end
      if (rxValid_out) break;
    end
    serData_in = 1'b1;
    checkOutput("rdAckPulse", extraAck, 0);
    checkOutput("rxSdoIdle", sdoLow, 0);
    if (idle >= HUNT_MAX) begin
      checkOutput("timeoutSeen", sawTimeout, 1);
      checkOutput("huntRises", rises, HUNT_MAX);
      checkOutput("timeoutNoData", rxValid_out, 0);
      checkOutput("timeoutIdle", txReady_out, 1);
      tick();
      checkOutput("timeoutPulse", timeout_out, 0);
    end else begin
      checkOutput("rxNoTimeout", sawTimeout, 0);
      checkOutput("rxValid", rxValid_out, 1);
      checkOutput("rxData", rxData_out, b);
      checkOutput("rxRises", rises, idle + 9);
    end
  endtask

  task automatic releaseByte();
    rxReady_in = 1'b1;
    tick();
    rxReady_in = 1'b0;
    checkOutput("rxRelease", rxValid_out, 0);
  endtask

  task automatic applyStimulus(input int kind, input logic [7:0] data, input int param);
    int ack;
    if (kind == 0) begin
      doTx(data, param, ack);
    end else begin
      doRead(data, param);
      if (rxValid_out) releaseByte();
    end
    repeat ($urandom_range(1, 5)) tick();
  endtask

  initial begin
    int ack, n;
    logic [7:0] d;
    $display("[TB] starting ss_host_master bench");
    repeat (3) tick();
    checkOutput("rstSerClk", serClk_out, 1);
    checkOutput("rstSerData", serData_out, 1);
    checkOutput("rstTxReady", txReady_out, 0);
    checkOutput("rstRdAck", rdAck_out, 0);
    checkOutput("rstRxValid", rxValid_out, 0);
    checkOutput("rstRxData", rxData_out, 0);
    checkOutput("rstTimeout", timeout_out, 0);
    reset_in = 1'b1;
    tick();
    checkOutput("idleTxReady", txReady_out, 1);
    repeat (2) tick();

    doTx(8'hA5, 0, ack);
    repeat (3) tick();
    doTx(8'h3C, 50, ack);
    repeat (3) tick();

    doRead(8'h96, 5);
    rdReq_in = 1'b1;
    rxReady_in = 1'b0;
    n = 0;
    repeat (30) begin
      tick();
      if (rdAck_out) n++;
    end
    checkOutput("heldNoAck", n, 0);
    checkOutput("heldValid", rxValid_out, 1);
    rxReady_in = 1'b1;
    tick();
    rxReady_in = 1'b0;
    checkOutput("heldRelease", rxValid_out, 0);
    checkOutput("heldAckNotYet", rdAck_out, 0);
    tick();
    checkOutput("earliestAck", rdAck_out, 1);
    doRead(8'h5B, 2);
    releaseByte();
    repeat (3) tick();

    doRead(8'h00, HUNT_MAX + 4);
    repeat (3) tick();

    rdReq_in = 1'b1;
    doTx(8'hC3, 0, ack);
    checkOutput("arbTxFirst", ack, 0);
    doRead(8'h81, 3);
    releaseByte();
    repeat (3) tick();

    for (int i = 0; i < 14; i++) begin
      d = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 0)
        applyStimulus(0, d, ($urandom_range(0, 3) == 0) ? $urandom_range(5, 40) : 0);
      else
        applyStimulus(1, d, $urandom_range(0, HUNT_MAX + 4));
    end

    txData_in = 8'h00;
    txValid_in = 1'b1;
    tick();
    txValid_in = 1'b0;
    n = 0;
    while (serClk_out !== 1'b0 && n < 20) begin
      tick();
      n++;
    end
    repeat (2 * CLK_DIV * 3) tick();
    while (serClk_out !== 1'b0 && n < 40) begin
      tick();
      n++;
    end
    reset_in = 1'b0;
    #1;
    checkOutput("midRstSerClk", serClk_out, 1);
    checkOutput("midRstSerData", serData_out, 1);
    checkOutput("midRstTxReady", txReady_out, 0);
    repeat (2) tick();
    reset_in = 1'b1;
    tick();
    checkOutput("postRstReady", txReady_out, 1);
    doTx(8'h6E, 0, ack);
    repeat (3) tick();

    checkOutput("lineOrder", lineViol, 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
